// File: rtl/adsr_envelope.sv
// ============================================================================
// Module   : adsr_envelope
// Brief    : Per-voice ADSR envelope generator with a VCA sample multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adsr_envelope #(
  parameter int LEVEL_W  = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SAMPLE_TICK,
  input  logic                KEY,
  input  logic [LEVEL_W-1:0]  ATTACK,
  input  logic [LEVEL_W-1:0]  DECAY,
  input  logic [LEVEL_W-1:0]  SUSTAIN,
  input  logic [LEVEL_W-1:0]  RLEASE,
  input  logic [SAMPLE_W-1:0] SAMPLE_IN,
  output logic [LEVEL_W-1:0]  ENV,
  output logic                ENV_STROBE,
  output logic                ACTIVE,
  output logic [2:0]          STATE,
  output logic [SAMPLE_W-1:0] OUT_SAMPLE,
  output logic                OUT_VALID
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ATTACK  = 3'd1;
  localparam logic [2:0] c_DECAY   = 3'd2;
  localparam logic [2:0] c_SUSTAIN = 3'd3;
  localparam logic [2:0] c_RELEASE = 3'd4;

  localparam logic [LEVEL_W-1:0] c_LEVEL_MAX = '1;
  localparam int                 c_PROD_W    = SAMPLE_W + LEVEL_W;

  logic [2:0]          r_state;
  logic [LEVEL_W-1:0]  r_level;
  logic                r_key_q;
  logic [SAMPLE_W-1:0] r_sample_q;
  logic                r_env_strobe;
  logic [SAMPLE_W-1:0] r_out_sample;
  logic                r_out_valid;

  logic [2:0]          w_next_state;
  logic [LEVEL_W-1:0]  w_next_level;
  logic [LEVEL_W:0]    w_attack_sum;
  logic [LEVEL_W:0]    w_decay_floor;
  logic [c_PROD_W-1:0] w_sample_ext;
  logic [c_PROD_W-1:0] w_env_ext;
  logic signed [c_PROD_W-1:0] w_product;

  // Sums are one bit wider than the level so they can never wrap.
  assign w_attack_sum  = {1'b0, r_level} + {1'b0, ATTACK};
  assign w_decay_floor = {1'b0, SUSTAIN} + {1'b0, DECAY};

  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    if (KEY && !r_key_q) begin
      w_next_state = c_ATTACK;
    end else if (!KEY && (r_state == c_ATTACK || r_state == c_DECAY ||
                          r_state == c_SUSTAIN)) begin
      w_next_state = c_RELEASE;
    end else begin
      case (r_state)
        c_IDLE: w_next_level = '0;
        c_ATTACK: begin
          if (ATTACK == '0 || w_attack_sum >= {1'b0, c_LEVEL_MAX}) begin
            w_next_level = c_LEVEL_MAX;
            w_next_state = c_DECAY;
          end else begin
            w_next_level = w_attack_sum[LEVEL_W-1:0];
          end
        end
        c_DECAY: begin
          if (DECAY == '0 || {1'b0, r_level} <= w_decay_floor) begin
            w_next_level = SUSTAIN;
            w_next_state = c_SUSTAIN;
          end else begin
            w_next_level = r_level - DECAY;
          end
        end
        c_SUSTAIN: w_next_level = SUSTAIN;
        c_RELEASE: begin
          if (RLEASE == '0 || r_level <= RLEASE) begin
            w_next_level = '0;
            w_next_state = c_IDLE;
          end else begin
            w_next_level = r_level - RLEASE;
          end
        end
        default: begin
          w_next_level = '0;
          w_next_state = c_IDLE;
        end
      endcase
    end
  end

  // Sign-extended sample times zero-extended level; the product always fits.
  assign w_sample_ext = {{LEVEL_W{r_sample_q[SAMPLE_W-1]}}, r_sample_q};
  assign w_env_ext    = {{SAMPLE_W{1'b0}}, r_level};
  assign w_product    = $signed(w_sample_ext * w_env_ext);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= c_IDLE;
      r_level      <= '0;
      r_key_q      <= 1'b0;
      r_sample_q   <= '0;
      r_env_strobe <= 1'b0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_env_strobe <= SAMPLE_TICK;
      r_out_valid  <= r_env_strobe;
      if (SAMPLE_TICK) begin
        r_state    <= w_next_state;
        r_level    <= w_next_level;
        r_key_q    <= KEY;
        r_sample_q <= SAMPLE_IN;
      end
      if (r_env_strobe) begin
        r_out_sample <= SAMPLE_W'(w_product >>> LEVEL_W);
      end
    end
  end

  assign ENV        = r_level;
  assign ENV_STROBE = r_env_strobe;
  assign ACTIVE     = (r_state != c_IDLE);
  assign STATE      = r_state;
  assign OUT_SAMPLE = r_out_sample;
  assign OUT_VALID  = r_out_valid;

endmodule

`default_nettype wire
